systolic_mac_pe: RTL and testbench

- Single processing element of a weight/operand-streaming systolic array.
- Each cycle it multiplies two unsigned 8-bit operands and adds the product to an incoming 19-bit partial sum. The result is registered to `sum_out`.
- Both operands are forwarded, registered, to the neighbouring PEs (`a` flows east, `b` flows south).
- 19-bit sum width covers the accumulation of up to 8 full-scale 16-bit products.

---
 rtl/systolic_mac_pe_if.sv | 46 ++++
 rtl/systolic_mac_pe.sv | 78 +++++++
 tb/tb_systolic_mac_pe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_mac_pe_if.sv
// -----------------------------------------------------------------------------
// systolic_mac_pe_if
//   Groups the operand and partial-sum bus of one systolic MAC processing
//   element.
//
//   Signals:
//     a_in    : operand A arriving from the west neighbour
//     b_in    : operand B arriving from the north neighbour
//     sum_in  : partial sum arriving from the upstream PE
//     sum_out : registered sum_in + a_in*b_in
//     a_out   : registered copy of a_in, towards the east neighbour
//     b_out   : registered copy of b_in, towards the south neighbour
//
//   Modports:
//     slave  : the PE itself (consumes *_in, produces *_out)
//     master : whatever surrounds the PE (array fabric or testbench)
// -----------------------------------------------------------------------------
interface systolic_mac_pe_if #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 19
);
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic [SUM_W-1:0]  sum_in;
    logic [SUM_W-1:0]  sum_out;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;

    modport slave (
        input  a_in,
        input  b_in,
        input  sum_in,
        output sum_out,
        output a_out,
        output b_out
    );

    modport master (
        output a_in,
        output b_in,
        output sum_in,
        input  sum_out,
        input  a_out,
        input  b_out
    );
endinterface : systolic_mac_pe_if

// File: rtl/systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// systolic_mac_pe
//   One processing element of an operand-streaming systolic array. Every
//   cycle it multiplies two unsigned operands, adds the product to the
//   incoming partial sum and registers the result. Both operands are also
//   registered and forwarded to the neighbouring PEs. There is no enable and
//   no handshake: a new set of inputs is accepted on every rising edge.
//
//   Ports:
//     clk   : rising-edge clock, all state lives on it
//     reset : asynchronous active-low reset; clears every register at once,
//             release takes effect on the next rising edge
//     bus   : systolic_mac_pe_if.slave (a_in, b_in, sum_in -> sum_out,
//             a_out, b_out), all outputs with exactly one cycle of latency
//
//   Parameters:
//     DATA_W : operand width (unsigned)
//     SUM_W  : partial-sum width; must be at least 2*DATA_W. The default of
//              19 holds the sum of eight full-scale 16-bit products.
// -----------------------------------------------------------------------------
module systolic_mac_pe #(
    parameter int DATA_W = 8,
    parameter int SUM_W  = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    systolic_mac_pe_if.slave      bus
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] product;
    logic [SUM_W-1:0]  sum_d,  sum_q;
    logic [DATA_W-1:0] a_d,    a_q;
    logic [DATA_W-1:0] b_d,    b_q;

    // Multiply-add in a single combinational stage feeding the output
    // registers; the critical path is deliberately multiply plus add.
    always_comb begin
        // NOTE: every signal written here gets a value on every pass through
        // the block, so no latch can be inferred.
        product = '0;
        sum_d   = '0;
        a_d     = '0;
        b_d     = '0;

        // Operands are widened before the multiply so the full unsigned
        // product is formed (8'hFF is 255, never -1).
        product = PROD_W'(bus.a_in) * PROD_W'(bus.b_in);

        // Zero-extended product; the SUM_W-bit result wraps silently on
        // overflow, there is intentionally no saturation or carry out.
        sum_d   = bus.sum_in + SUM_W'(product);
        a_d     = bus.a_in;
        b_d     = bus.b_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // values that existed before this edge, independent of the order
            // of statements.
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    // Outputs come straight from flops: no input-to-output combinational path.
    assign bus.sum_out = sum_q;
    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;

endmodule : systolic_mac_pe

// File: tb/tb_systolic_mac_pe.sv
// -----------------------------------------------------------------------------
// tb_systolic_mac_pe
//   Self-checking bench for systolic_mac_pe. A behavioural model computes the
//   expected outputs with plain arithmetic ((sum + a*b) mod 2^19, delayed
//   copies of the operands, zero while in reset). A compare process checks
//   the DUT against the model on every falling clock edge; directed steps
//   additionally pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_systolic_mac_pe;

    localparam int DATA_W = 8;
    localparam int SUM_W  = 19;
    localparam longint SUM_MOD = 64'd1 << SUM_W;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    systolic_mac_pe_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

    systolic_mac_pe #(.DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    int unsigned exp_sum = 0;
    int unsigned exp_a   = 0;
    int unsigned exp_b   = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_sum = 0;
            exp_a   = 0;
            exp_b   = 0;
        end else begin
            exp_sum = int'((longint'(bus.sum_in) +
                            longint'(bus.a_in) * longint'(bus.b_in)) % SUM_MOD);
            exp_a   = int'(bus.a_in);
            exp_b   = int'(bus.b_in);
        end
    end

    // ---------------------------------------------------------------- check
    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_sum_out", 32'(bus.sum_out), exp_sum);
        check("model_a_out",   32'(bus.a_out),   exp_a);
        check("model_b_out",   32'(bus.b_out),   exp_b);
    end

    // ---------------------------------------------------------------- helpers
    // Advance to just after the next rising edge; inputs are changed here so
    // they are stable well before the following edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int unsigned a, input int unsigned b,
                         input int unsigned s);
        bus.a_in   = DATA_W'(a);
        bus.b_in   = DATA_W'(b);
        bus.sum_in = SUM_W'(s);
    endtask

    task automatic expect_out(input string name, input int unsigned s,
                              input int unsigned a, input int unsigned b);
        check({name, "_sum"}, 32'(bus.sum_out), s);
        check({name, "_a"},   32'(bus.a_out),   a);
        check({name, "_b"},   32'(bus.b_out),   b);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------------------------------------------------------- stimulus
    initial begin
        reset = 1'b0;
        drive(8'hAA, 8'h55, 19'h7FFFF);

        // Reset held across several clock edges: outputs stay zero.
        repeat (3) begin
            step();
            expect_out("reset_hold", 0, 0, 0);
        end

        // Release between edges; first capture on the next rising edge.
        reset = 1'b1;
        step();
        expect_out("reset_release", 14449, 170, 85);

        // Basic MAC, including hold-before-edge.
        drive(3, 5, 10);
        #2;
        expect_out("basic_hold", 14449, 170, 85);
        step();
        expect_out("basic", 25, 3, 5);

        // Zero operand pass-through.
        drive(0, 200, 1234);
        step();
        expect_out("zero_a", 1234, 0, 200);
        drive(77, 0, 524287);
        step();
        expect_out("zero_b", 524287, 77, 0);

        // Overflow wrap and full-scale product.
        drive(255, 255, 524287);
        step();
        expect_out("wrap", 65024, 255, 255);
        drive(255, 255, 0);
        step();
        expect_out("max_prod", 65025, 255, 255);

        // Back-to-back stream.
        drive(1, 2, 100);
        step();
        expect_out("stream0", 102, 1, 2);
        drive(4, 4, 0);
        step();
        expect_out("stream1", 16, 4, 4);
        drive(10, 20, 7);
        step();
        expect_out("stream2", 207, 10, 20);

        // Asynchronous reset between edges: outputs clear without an edge.
        #2;
        reset = 1'b0;
        #1;
        expect_out("async_reset", 0, 0, 0);
        step();
        expect_out("async_reset_edge", 0, 0, 0);
        reset = 1'b1;
        drive(2, 3, 1);
        step();
        expect_out("resume", 7, 2, 3);

        // Randomised traffic with extremes and occasional mid-cycle resets;
        // the compare process checks every cycle against the model.
        for (int i = 0; i < 400; i++) begin
            int unsigned a, b, s;
            a = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            s = $urandom_range(0, 524287);
            case ($urandom_range(0, 7))
                0: a = 255;
                1: b = 0;
                2: s = 524287;
                3: begin a = 255; b = 255; end
                default: ;
            endcase
            drive(a, b, s);
            if ($urandom_range(0, 31) == 0) begin
                #1;
                reset = 1'b0;
                #1;
                check("rand_async_sum", 32'(bus.sum_out), 0);
                reset = 1'b1;
            end
            step();
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_systolic_mac_pe
